inst_fetch: RTL

Instruction fetch stage: owns the architectural fetch PC and issues one instruction read at a time over an SRAM-like request/response interface. It presents the fetched `inst`/`pc` pair to the decode stage through a single-entry output register with a valid/ready handshake. It also applies taken-branch and jump redirects reported back by decode.

---
 rtl/inst_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one SRAM-like read at a
// time and hands inst/pc pairs to decode through a single-entry register.
module inst_fetch #(
   parameter int unsigned     ADDR_WIDTH = 32,
   parameter int unsigned     INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1C00_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  inst_req,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  inst_addr_ok,
   input  logic [INST_WIDTH-1:0] inst_rdata,
   input  logic                  inst_data_ok,
   output logic                  if_valid,
   output logic [INST_WIDTH-1:0] if_inst,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  id_ready,
   input  logic                  branch_en,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   input  logic [ADDR_WIDTH-1:0] jump_addr
);

   typedef enum logic [1:0] {
      S_RESET,
      S_REQ,
      S_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetchPc_q, fetchPc_d;
   logic                  discard_q, discard_d;
   logic                  ifValid_q, ifValid_d;
   logic [INST_WIDTH-1:0] ifInst_q, ifInst_d;
   logic [ADDR_WIDTH-1:0] ifPc_q, ifPc_d;

   logic                  consume;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] targetRaw;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] pcPlus4;

   // The consumed entry is the branch itself, so redirect only counts on a consume.
   assign consume   = ifValid_q & id_ready;
   assign redirect  = consume & (branch_en | jump_en);
   assign targetRaw = jump_en ? jump_addr : branch_addr;
   assign target    = {targetRaw[ADDR_WIDTH-1:2], 2'b00};
   assign pcPlus4   = fetchPc_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

   assign inst_addr = fetchPc_q;
   assign if_valid  = ifValid_q;
   assign if_inst   = ifInst_q;
   assign if_pc     = ifPc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_RESET;
         fetchPc_q <= RESET_PC;
         discard_q <= 1'b0;
         ifValid_q <= 1'b0;
         ifInst_q  <= '0;
         ifPc_q    <= '0;
      end else begin
         state_q   <= state_d;
         fetchPc_q <= fetchPc_d;
         discard_q <= discard_d;
         ifValid_q <= ifValid_d;
         ifInst_q  <= ifInst_d;
         ifPc_q    <= ifPc_d;
      end
   end

   // A request is only issued when the output entry is guaranteed free on return,
   // so a load in WAIT can never overwrite an unconsumed instruction.
   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      discard_d = discard_q;
      ifValid_d = ifValid_q & ~consume;
      ifInst_d  = ifInst_q;
      ifPc_d    = ifPc_q;
      inst_req  = 1'b0;

      case (state_q)
         S_RESET: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            inst_req = ~ifValid_q | id_ready;
            if (redirect) begin
               fetchPc_d = target;
               if (inst_req && inst_addr_ok) begin
                  discard_d = 1'b1;
                  state_d   = S_WAIT;
               end
            end else if (inst_req && inst_addr_ok) begin
               discard_d = 1'b0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_data_ok) begin
               state_d = S_REQ;
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  if (redirect) begin
                     fetchPc_d = target;
                  end
               end else begin
                  ifValid_d = 1'b1;
                  ifInst_d  = inst_rdata;
                  ifPc_d    = fetchPc_q;
                  fetchPc_d = pcPlus4;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
               fetchPc_d = target;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

endmodule
